// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with valid bit, flush/freeze handling and forwarding operand muxes.
// Latency: one cycle from ID inputs to EX registered outputs; opA/opB are combinational from selSrc*.
// Backpressure: freeze holds every register; flush turns the captured instruction into a bubble.
module id_ex_stage_reg #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 4,
    parameter int SHIFT_W = 12,
    parameter int IMM24_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               flush,
    input  logic               validID,
    input  logic [DATA_W-1:0]  pcID,
    input  logic [DATA_W-1:0]  valRnID,
    input  logic [DATA_W-1:0]  valRmID,
    input  logic [REG_W-1:0]   src1ID,
    input  logic [REG_W-1:0]   src2ID,
    input  logic [REG_W-1:0]   destID,
    input  logic               wbEnID,
    input  logic               memREnID,
    input  logic               memWEnID,
    input  logic               bID,
    input  logic               sID,
    input  logic               immID,
    input  logic               carryID,
    input  logic [3:0]         exeCmdID,
    input  logic [SHIFT_W-1:0] shiftOperandID,
    input  logic [IMM24_W-1:0] signedImm24ID,
    input  logic [1:0]         selSrc1,
    input  logic [1:0]         selSrc2,
    input  logic [DATA_W-1:0]  aluResMEM,
    input  logic [DATA_W-1:0]  wbValueWB,
    output logic               validEX,
    output logic [DATA_W-1:0]  pcEX,
    output logic [DATA_W-1:0]  valRnEX,
    output logic [DATA_W-1:0]  valRmEX,
    output logic [REG_W-1:0]   src1EX,
    output logic [REG_W-1:0]   src2EX,
    output logic [REG_W-1:0]   destEX,
    output logic               wbEnEX,
    output logic               memREnEX,
    output logic               memWEnEX,
    output logic               bEX,
    output logic               sEX,
    output logic               immEX,
    output logic               carryEX,
    output logic [3:0]         exeCmdEX,
    output logic [SHIFT_W-1:0] shiftOperandEX,
    output logic [IMM24_W-1:0] signedImm24EX,
    output logic [DATA_W-1:0]  opA,
    output logic [DATA_W-1:0]  opB
);

    // Datapath fields: always captured (even on flush) so a squashed
    // instruction stays visible in EX for debug.
    typedef struct packed {
        logic [DATA_W-1:0]  pc;
        logic [DATA_W-1:0]  val_rn;
        logic [DATA_W-1:0]  val_rm;
        logic [REG_W-1:0]   src1;
        logic [REG_W-1:0]   src2;
        logic [REG_W-1:0]   dest;
        logic               imm;
        logic               carry;
        logic [3:0]         exe_cmd;
        logic [SHIFT_W-1:0] shift_operand;
        logic [IMM24_W-1:0] signed_imm24;
    } data_t;

    // Side-effect controls: forced to zero for any bubble so nothing
    // downstream writes back, touches memory, branches or sets flags.
    typedef struct packed {
        logic wb_en;
        logic mem_r_en;
        logic mem_w_en;
        logic b;
        logic s;
    } ctrl_t;

    data_t data_id;
    data_t data_q;
    ctrl_t ctrl_id;
    ctrl_t ctrl_q;
    logic  valid_q;

    assign data_id.pc            = pcID;
    assign data_id.val_rn        = valRnID;
    assign data_id.val_rm        = valRmID;
    assign data_id.src1          = src1ID;
    assign data_id.src2          = src2ID;
    assign data_id.dest          = destID;
    assign data_id.imm           = immID;
    assign data_id.carry         = carryID;
    assign data_id.exe_cmd       = exeCmdID;
    assign data_id.shift_operand = shiftOperandID;
    assign data_id.signed_imm24  = signedImm24ID;

    assign ctrl_id.wb_en    = wbEnID;
    assign ctrl_id.mem_r_en = memREnID;
    assign ctrl_id.mem_w_en = memWEnID;
    assign ctrl_id.b        = bID;
    assign ctrl_id.s        = sID;

    // Stage register: flush beats freeze, freeze holds everything, otherwise load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            data_q  <= data_id;
            ctrl_q  <= '0;
        end else if (!freeze) begin
            valid_q <= validID;
            data_q  <= data_id;
            ctrl_q  <= validID ? ctrl_id : '0;
        end
    end

    assign validEX        = valid_q;
    assign pcEX           = data_q.pc;
    assign valRnEX        = data_q.val_rn;
    assign valRmEX        = data_q.val_rm;
    assign src1EX         = data_q.src1;
    assign src2EX         = data_q.src2;
    assign destEX         = data_q.dest;
    assign immEX          = data_q.imm;
    assign carryEX        = data_q.carry;
    assign exeCmdEX       = data_q.exe_cmd;
    assign shiftOperandEX = data_q.shift_operand;
    assign signedImm24EX  = data_q.signed_imm24;
    assign wbEnEX         = ctrl_q.wb_en;
    assign memREnEX       = ctrl_q.mem_r_en;
    assign memWEnEX       = ctrl_q.mem_w_en;
    assign bEX            = ctrl_q.b;
    assign sEX            = ctrl_q.s;

    // Forwarding operand muxes: 01 takes MEM, 10 takes WB, 00/11 keep the register value.
    always_comb begin
        opA = data_q.val_rn;
        unique case (selSrc1)
            2'b01:   opA = aluResMEM;
            2'b10:   opA = wbValueWB;
            default: opA = data_q.val_rn;
        endcase
    end

    // Same selection for the Rm path (shifter input and store data).
    always_comb begin
        opB = data_q.val_rm;
        unique case (selSrc2)
            2'b01:   opB = aluResMEM;
            2'b10:   opB = wbValueWB;
            default: opB = data_q.val_rm;
        endcase
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for the ID->EX stage register: scoreboard of expected EX states,
// pushed when ID stimulus is applied and popped after the capturing edge.
module tb_id_ex_stage_reg;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        flush;
    logic        validID;
    logic [31:0] pcID, valRnID, valRmID;
    logic [3:0]  src1ID, src2ID, destID;
    logic        wbEnID, memREnID, memWEnID, bID, sID, immID, carryID;
    logic [3:0]  exeCmdID;
    logic [11:0] shiftOperandID;
    logic [23:0] signedImm24ID;
    logic [1:0]  selSrc1, selSrc2;
    logic [31:0] aluResMEM, wbValueWB;

    logic        validEX;
    logic [31:0] pcEX, valRnEX, valRmEX;
    logic [3:0]  src1EX, src2EX, destEX;
    logic        wbEnEX, memREnEX, memWEnEX, bEX, sEX, immEX, carryEX;
    logic [3:0]  exeCmdEX;
    logic [11:0] shiftOperandEX;
    logic [23:0] signedImm24EX;
    logic [31:0] opA, opB;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  dest;
        logic        wb;
        logic        mr;
        logic        mw;
        logic        b;
        logic        s;
        logic        imm;
        logic        carry;
        logic [3:0]  cmd;
        logic [11:0] shift;
        logic [23:0] imm24;
    } st_t;

    st_t model_reg;
    st_t sb_q[$];
    int  total = 0;
    int  bad   = 0;

    id_ex_stage_reg dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .validID(validID),
        .pcID(pcID), .valRnID(valRnID), .valRmID(valRmID),
        .src1ID(src1ID), .src2ID(src2ID), .destID(destID),
        .wbEnID(wbEnID), .memREnID(memREnID), .memWEnID(memWEnID),
        .bID(bID), .sID(sID), .immID(immID), .carryID(carryID),
        .exeCmdID(exeCmdID), .shiftOperandID(shiftOperandID), .signedImm24ID(signedImm24ID),
        .selSrc1(selSrc1), .selSrc2(selSrc2), .aluResMEM(aluResMEM), .wbValueWB(wbValueWB),
        .validEX(validEX), .pcEX(pcEX), .valRnEX(valRnEX), .valRmEX(valRmEX),
        .src1EX(src1EX), .src2EX(src2EX), .destEX(destEX),
        .wbEnEX(wbEnEX), .memREnEX(memREnEX), .memWEnEX(memWEnEX),
        .bEX(bEX), .sEX(sEX), .immEX(immEX), .carryEX(carryEX),
        .exeCmdEX(exeCmdEX), .shiftOperandEX(shiftOperandEX), .signedImm24EX(signedImm24EX),
        .opA(opA), .opB(opB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic st_t id_state();
        st_t t;
        t.valid = validID;   t.pc = pcID;       t.rn = valRnID;    t.rm = valRmID;
        t.src1 = src1ID;     t.src2 = src2ID;   t.dest = destID;
        t.wb = wbEnID;       t.mr = memREnID;   t.mw = memWEnID;   t.b = bID;  t.s = sID;
        t.imm = immID;       t.carry = carryID; t.cmd = exeCmdID;
        t.shift = shiftOperandID;               t.imm24 = signedImm24ID;
        return t;
    endfunction

    function automatic st_t dut_state();
        st_t t;
        t.valid = validEX;   t.pc = pcEX;       t.rn = valRnEX;    t.rm = valRmEX;
        t.src1 = src1EX;     t.src2 = src2EX;   t.dest = destEX;
        t.wb = wbEnEX;       t.mr = memREnEX;   t.mw = memWEnEX;   t.b = bEX;  t.s = sEX;
        t.imm = immEX;       t.carry = carryEX; t.cmd = exeCmdEX;
        t.shift = shiftOperandEX;               t.imm24 = signedImm24EX;
        return t;
    endfunction

    // Reference behaviour of one rising edge with reset released.
    function automatic st_t next_model(st_t cur);
        st_t n;
        n = id_state();
        if (flush) begin
            n.valid = 1'b0; n.wb = 1'b0; n.mr = 1'b0; n.mw = 1'b0; n.b = 1'b0; n.s = 1'b0;
        end else if (freeze) begin
            n = cur;
        end else if (!validID) begin
            n.wb = 1'b0; n.mr = 1'b0; n.mw = 1'b0; n.b = 1'b0; n.s = 1'b0;
        end
        return n;
    endfunction

    function automatic logic [31:0] fwd(logic [1:0] sel, logic [31:0] regv);
        if (sel == 2'b01)      return aluResMEM;
        else if (sel == 2'b10) return wbValueWB;
        else                   return regv;
    endfunction

    task automatic rand_id();
        validID = 1'($urandom_range(0, 1));
        pcID = $urandom; valRnID = $urandom; valRmID = $urandom;
        src1ID = 4'($urandom); src2ID = 4'($urandom); destID = 4'($urandom);
        wbEnID = 1'($urandom_range(0, 1)); memREnID = 1'($urandom_range(0, 1));
        memWEnID = 1'($urandom_range(0, 1)); bID = 1'($urandom_range(0, 1));
        sID = 1'($urandom_range(0, 1)); immID = 1'($urandom_range(0, 1));
        carryID = 1'($urandom_range(0, 1)); exeCmdID = 4'($urandom);
        shiftOperandID = 12'($urandom); signedImm24ID = 24'($urandom);
    endtask

    // Push the expected state for this edge, clock, then pop and compare.
    task automatic drive_cycle(input string name);
        st_t e;
        st_t got;
        e = next_model(model_reg);
        sb_q.push_back(e);
        model_reg = e;
        @(posedge clk);
        #1;
        got = dut_state();
        e = sb_q.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; freeze = 1'b0; flush = 1'b0;
        selSrc1 = 2'b00; selSrc2 = 2'b11;
        aluResMEM = 32'h1234_5678; wbValueWB = 32'h9abc_def0;
        for (int i = 0; i < 2; i++) begin
            rand_id();
            flush = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            total++;
            if (dut_state() !== st_t'('0)) begin
                bad++;
                $display("FAIL reset_state got=%h exp=0", dut_state());
            end
        end
        total++;
        if (opA !== 32'h0 || opB !== 32'h0) begin
            bad++;
            $display("FAIL reset_ops opA=%h opB=%h exp=0", opA, opB);
        end
        selSrc1 = 2'b01;
        #1;
        total++;
        if (opA !== 32'h1234_5678) begin
            bad++;
            $display("FAIL reset_opA_mem got=%h exp=12345678", opA);
        end
        selSrc1 = 2'b00;
        flush = 1'b0;
        model_reg = '0;
    endtask

    task automatic test_load();
        rand_id();
        rst = 1'b1;
        validID = 1'b1; pcID = 32'h10; valRnID = 32'd5; destID = 4'd3; wbEnID = 1'b1;
        drive_cycle("reset_then_load");
        total++;
        if (pcEX !== 32'h10 || valRnEX !== 32'd5 || destEX !== 4'd3 || wbEnEX !== 1'b1 || validEX !== 1'b1) begin
            bad++;
            $display("FAIL load_fields pc=%h rn=%h dest=%h wb=%b v=%b", pcEX, valRnEX, destEX, wbEnEX, validEX);
        end
    endtask

    task automatic test_freeze();
        rand_id(); validID = 1'b1;
        drive_cycle("freeze_load_a");
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_id();
            selSrc1 = 2'($urandom); selSrc2 = 2'($urandom);
            drive_cycle("freeze_hold");
        end
        selSrc1 = 2'b00; selSrc2 = 2'b00;
        freeze = 1'b0;
        rand_id(); validID = 1'b1;
        drive_cycle("freeze_release");
    endtask

    task automatic test_flush();
        rand_id();
        freeze = 1'b1; flush = 1'b1; validID = 1'b1;
        wbEnID = 1'b1; memWEnID = 1'b1; bID = 1'b1; sID = 1'b1; memREnID = 1'b1;
        drive_cycle("flush_over_freeze");
        total++;
        if (validEX !== 1'b0 || wbEnEX !== 1'b0 || memWEnEX !== 1'b0 || bEX !== 1'b0 || sEX !== 1'b0) begin
            bad++;
            $display("FAIL flush_ctrl v=%b wb=%b mw=%b b=%b s=%b exp all 0", validEX, wbEnEX, memWEnEX, bEX, sEX);
        end
        freeze = 1'b0; flush = 1'b0;
        rand_id(); validID = 1'b0; wbEnID = 1'b1; memREnID = 1'b1; bID = 1'b1;
        drive_cycle("bubble_ctrl_gated");
    endtask

    task automatic test_forward();
        logic [31:0] exp_a [4];
        logic [1:0]  sels  [4];
        exp_a[0] = 32'd7;  exp_a[1] = 32'h20; exp_a[2] = 32'h30; exp_a[3] = 32'd7;
        sels[0] = 2'b00;   sels[1] = 2'b01;   sels[2] = 2'b10;   sels[3] = 2'b11;
        rand_id(); validID = 1'b1; valRnID = 32'd7;
        drive_cycle("fwd_load");
        aluResMEM = 32'h20; wbValueWB = 32'h30;
        for (int i = 0; i < 4; i++) begin
            selSrc1 = sels[i];
            #1;
            total++;
            if (opA !== exp_a[i]) begin
                bad++;
                $display("FAIL fwd_opA sel=%b got=%h exp=%h", sels[i], opA, exp_a[i]);
            end
        end
        selSrc1 = 2'b00;
    endtask

    task automatic test_store_fwd();
        rand_id(); validID = 1'b1; memWEnID = 1'b1; valRmID = 32'd1;
        drive_cycle("store_load");
        selSrc2 = 2'b10; wbValueWB = 32'hAB;
        #1;
        total++;
        if (opB !== 32'hAB || memWEnEX !== 1'b1) begin
            bad++;
            $display("FAIL store_fwd opB=%h mw=%b exp=000000ab mw=1", opB, memWEnEX);
        end
        selSrc2 = 2'b00;
    endtask

    task automatic test_async_reset();
        rand_id(); validID = 1'b1; wbEnID = 1'b1;
        drive_cycle("areset_load");
        freeze = 1'b1;
        rand_id();
        drive_cycle("areset_frozen");
        #2 rst = 1'b0;
        #1;
        total++;
        if (dut_state() !== st_t'('0) || opA !== 32'h0) begin
            bad++;
            $display("FAIL async_reset got=%h opA=%h exp=0", dut_state(), opA);
        end
        #1 rst = 1'b1;
        model_reg = '0;
        freeze = 1'b0;
        rand_id(); validID = 1'b1;
        drive_cycle("after_async_reset");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            rand_id();
            freeze = ($urandom_range(0, 3) == 0);
            flush  = ($urandom_range(0, 4) == 0);
            drive_cycle("b2b_state");
            selSrc1 = 2'($urandom); selSrc2 = 2'($urandom);
            aluResMEM = $urandom; wbValueWB = $urandom;
            #1;
            total++;
            if (opA !== fwd(selSrc1, model_reg.rn) || opB !== fwd(selSrc2, model_reg.rm)) begin
                bad++;
                $display("FAIL b2b_ops sel=%b/%b opA=%h exp=%h opB=%h exp=%h", selSrc1, selSrc2,
                         opA, fwd(selSrc1, model_reg.rn), opB, fwd(selSrc2, model_reg.rm));
            end
        end
        freeze = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_freeze();
        test_flush();
        test_forward();
        test_store_fwd();
        test_async_reset();
        test_back_to_back();
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover entries=%0d exp=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
